// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the instruction-fetch (I) and load/store (D) requesters.
// Each port has one pending slot; slots are issued round-robin, one downstream access at a time.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_addr,
  input  logic [3:0]  i_rmask,
  output logic [31:0] i_rdata,
  output logic        i_resp,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_rmask,
  input  logic [3:0]  d_wmask,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_resp,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp,
  output logic        error
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } state_t;

  localparam logic        GNT_I    = 1'b0;
  localparam logic        GNT_D    = 1'b1;
  localparam logic [15:0] TMO_LIM  = 16'(TIMEOUT_CYCLES);
  localparam logic [15:0] TMO_LAST = TMO_LIM - 16'd1;
  localparam logic [15:0] TMO_MAX  = 16'hFFFF;

  function automatic logic word_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

  state_t      state_q;
  logic        last_gnt_q;
  logic [15:0] tmo_cnt_q;
  logic [15:0] tmo_cnt_d;

  logic        i_slot_vld_q;
  logic [31:0] i_slot_addr_q;
  logic [3:0]  i_slot_rmask_q;

  logic        d_slot_vld_q;
  logic [31:0] d_slot_addr_q;
  logic [3:0]  d_slot_rmask_q;
  logic [3:0]  d_slot_wmask_q;
  logic [31:0] d_slot_wdata_q;

  logic [31:0] i_rdata_q;
  logic        i_resp_q;
  logic [31:0] d_rdata_q;
  logic        d_resp_q;
  logic [31:0] mem_addr_q;
  logic [3:0]  mem_rmask_q;
  logic [3:0]  mem_wmask_q;
  logic [31:0] mem_wdata_q;
  logic        error_q;

  logic i_req_s;
  logic d_rd_s;
  logic d_wr_s;
  logic d_req_s;
  logic i_accept_s;
  logic d_accept_s;
  logic i_reject_s;
  logic d_reject_s;
  logic issue_i_s;
  logic issue_d_s;
  logic waiting_s;
  logic tmo_hit_s;
  logic spurious_s;
  logic err_set_s;

  // Request sampling: a slot only loads when it is free and the request is well formed.
  always_comb begin
    i_req_s    = (i_rmask != 4'h0);
    d_rd_s     = (d_rmask != 4'h0);
    d_wr_s     = (d_wmask != 4'h0);
    d_req_s    = d_rd_s | d_wr_s;
    i_accept_s = i_req_s & ~i_slot_vld_q & word_aligned(i_addr[1:0]);
    d_accept_s = d_req_s & ~(d_rd_s & d_wr_s) & ~d_slot_vld_q & word_aligned(d_addr[1:0]);
    i_reject_s = i_req_s & ~i_accept_s;
    d_reject_s = d_req_s & ~d_accept_s;
  end

  // Round-robin grant; on contention the port not granted last wins.
  always_comb begin
    issue_i_s = 1'b0;
    issue_d_s = 1'b0;
    if (state_q == IDLE) begin
      if (i_slot_vld_q && d_slot_vld_q) begin
        if (last_gnt_q == GNT_I) begin
          issue_d_s = 1'b1;
        end else begin
          issue_i_s = 1'b1;
        end
      end else if (i_slot_vld_q) begin
        issue_i_s = 1'b1;
      end else if (d_slot_vld_q) begin
        issue_d_s = 1'b1;
      end else begin
        issue_i_s = 1'b0;
      end
    end else begin
      issue_i_s = 1'b0;
    end
  end

  // Memory watchdog: counts silent WAIT cycles, saturating so the flag cannot re-arm.
  always_comb begin
    waiting_s  = (state_q == WAIT_I) || (state_q == WAIT_D);
    tmo_hit_s  = waiting_s && !mem_resp && (tmo_cnt_q == TMO_LAST);
    spurious_s = (state_q == IDLE) && mem_resp;
    err_set_s  = i_reject_s | d_reject_s | tmo_hit_s | spurious_s;
    tmo_cnt_d  = tmo_cnt_q;
    if (issue_i_s || issue_d_s) begin
      tmo_cnt_d = 16'd0;
    end else if (waiting_s && !mem_resp && (tmo_cnt_q != TMO_MAX)) begin
      tmo_cnt_d = tmo_cnt_q + 16'd1;
    end else begin
      tmo_cnt_d = tmo_cnt_q;
    end
  end

  // Arbiter FSM with pending slots and registered upstream/downstream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      last_gnt_q     <= GNT_I;
      tmo_cnt_q      <= 16'd0;
      i_slot_vld_q   <= 1'b0;
      i_slot_addr_q  <= 32'h0;
      i_slot_rmask_q <= 4'h0;
      d_slot_vld_q   <= 1'b0;
      d_slot_addr_q  <= 32'h0;
      d_slot_rmask_q <= 4'h0;
      d_slot_wmask_q <= 4'h0;
      d_slot_wdata_q <= 32'h0;
      i_rdata_q      <= 32'h0;
      i_resp_q       <= 1'b0;
      d_rdata_q      <= 32'h0;
      d_resp_q       <= 1'b0;
      mem_addr_q     <= 32'h0;
      mem_rmask_q    <= 4'h0;
      mem_wmask_q    <= 4'h0;
      mem_wdata_q    <= 32'h0;
      error_q        <= 1'b0;
    end else begin
      i_resp_q    <= 1'b0;
      i_rdata_q   <= 32'h0;
      d_resp_q    <= 1'b0;
      d_rdata_q   <= 32'h0;
      mem_rmask_q <= 4'h0;
      mem_wmask_q <= 4'h0;
      tmo_cnt_q   <= tmo_cnt_d;
      if (err_set_s) begin
        error_q <= 1'b1;
      end
      if (i_accept_s) begin
        i_slot_vld_q   <= 1'b1;
        i_slot_addr_q  <= i_addr;
        i_slot_rmask_q <= i_rmask;
      end
      if (d_accept_s) begin
        d_slot_vld_q   <= 1'b1;
        d_slot_addr_q  <= d_addr;
        d_slot_rmask_q <= d_rmask;
        d_slot_wmask_q <= d_wmask;
        d_slot_wdata_q <= d_wdata;
      end
      case (state_q)
        IDLE: begin
          if (issue_i_s) begin
            mem_addr_q  <= i_slot_addr_q;
            mem_rmask_q <= i_slot_rmask_q;
            last_gnt_q  <= GNT_I;
            state_q     <= WAIT_I;
          end else if (issue_d_s) begin
            mem_addr_q  <= d_slot_addr_q;
            mem_rmask_q <= d_slot_rmask_q;
            mem_wmask_q <= d_slot_wmask_q;
            mem_wdata_q <= d_slot_wdata_q;
            last_gnt_q  <= GNT_D;
            state_q     <= WAIT_D;
          end else begin
            state_q <= IDLE;
          end
        end
        WAIT_I: begin
          if (mem_resp) begin
            i_slot_vld_q <= 1'b0;
            i_resp_q     <= 1'b1;
            i_rdata_q    <= mem_rdata;
            state_q      <= IDLE;
          end else begin
            state_q <= WAIT_I;
          end
        end
        WAIT_D: begin
          if (mem_resp) begin
            d_slot_vld_q <= 1'b0;
            d_resp_q     <= 1'b1;
            // Writes complete with zero data regardless of what the memory drives.
            d_rdata_q    <= (d_slot_wmask_q != 4'h0) ? 32'h0 : mem_rdata;
            state_q      <= IDLE;
          end else begin
            state_q <= WAIT_D;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign i_rdata   = i_rdata_q;
  assign i_resp    = i_resp_q;
  assign d_rdata   = d_rdata_q;
  assign d_resp    = d_resp_q;
  assign mem_addr  = mem_addr_q;
  assign mem_rmask = mem_rmask_q;
  assign mem_wmask = mem_wmask_q;
  assign mem_wdata = mem_wdata_q;
  assign error     = error_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; stimulus driven and outputs sampled on the falling edge.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic [31:0] i_addr;
  logic [3:0]  i_rmask;
  logic [31:0] i_rdata;
  logic        i_resp;
  logic [31:0] d_addr;
  logic [3:0]  d_rmask;
  logic [3:0]  d_wmask;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_resp;
  logic [31:0] mem_addr;
  logic [3:0]  mem_rmask;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        error;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_addr(i_addr), .i_rmask(i_rmask), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_rmask(d_rmask), .d_wmask(d_wmask), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_addr = 32'h0; i_rmask = 4'h0;
    d_addr = 32'h0; d_rmask = 4'h0; d_wmask = 4'h0; d_wdata = 32'h0;
    mem_rdata = 32'h0; mem_resp = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (i_resp !== 1'b0) begin failures++; $display("FAIL rst_i_resp actual=%h expected=0", i_resp); end
    checks++; if (d_resp !== 1'b0) begin failures++; $display("FAIL rst_d_resp actual=%h expected=0", d_resp); end
    checks++; if (i_rdata !== 32'h0) begin failures++; $display("FAIL rst_i_rdata actual=%h expected=0", i_rdata); end
    checks++; if (d_rdata !== 32'h0) begin failures++; $display("FAIL rst_d_rdata actual=%h expected=0", d_rdata); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL rst_mem_addr actual=%h expected=0", mem_addr); end
    checks++; if (mem_rmask !== 4'h0 || mem_wmask !== 4'h0) begin failures++; $display("FAIL rst_mem_masks actual=%h/%h expected=0/0", mem_rmask, mem_wmask); end
    checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL rst_mem_wdata actual=%h expected=0", mem_wdata); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL rst_error actual=%h expected=0", error); end
  endtask

  task automatic test_single_i();
    i_addr = 32'h0000_0040; i_rmask = 4'hF;
    step(1);
    i_addr = 32'h0; i_rmask = 4'h0;
    checks++; if (mem_rmask !== 4'h0) begin failures++; $display("FAIL single_no_early_issue actual=%h expected=0", mem_rmask); end
    step(1);
    checks++; if (mem_rmask !== 4'hF) begin failures++; $display("FAIL single_rmask actual=%h expected=f", mem_rmask); end
    checks++; if (mem_addr !== 32'h0000_0040) begin failures++; $display("FAIL single_addr actual=%h expected=00000040", mem_addr); end
    checks++; if (mem_wmask !== 4'h0) begin failures++; $display("FAIL single_wmask actual=%h expected=0", mem_wmask); end
    step(1);
    checks++; if (mem_rmask !== 4'h0) begin failures++; $display("FAIL single_rmask_pulse actual=%h expected=0", mem_rmask); end
    step(3);
    checks++; if (i_resp !== 1'b0) begin failures++; $display("FAIL single_early_resp actual=%h expected=0", i_resp); end
    mem_resp = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step(1);
    mem_resp = 1'b0; mem_rdata = 32'h0;
    checks++; if (i_resp !== 1'b1) begin failures++; $display("FAIL single_i_resp actual=%h expected=1", i_resp); end
    checks++; if (i_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL single_i_rdata actual=%h expected=deadbeef", i_rdata); end
    checks++; if (d_resp !== 1'b0) begin failures++; $display("FAIL single_d_resp actual=%h expected=0", d_resp); end
    step(1);
    checks++; if (i_resp !== 1'b0 || i_rdata !== 32'h0) begin failures++; $display("FAIL single_resp_pulse actual=%h/%h expected=0/0", i_resp, i_rdata); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL single_error actual=%h expected=0", error); end
  endtask

  task automatic test_contention_first();
    do_reset();
    i_addr = 32'h0000_0080; i_rmask = 4'hF;
    d_addr = 32'h0000_0200; d_rmask = 4'hF;
    step(1);
    i_addr = 32'h0; i_rmask = 4'h0; d_addr = 32'h0; d_rmask = 4'h0;
    step(1);
    checks++; if (mem_addr !== 32'h0000_0200 || mem_rmask !== 4'hF) begin failures++; $display("FAIL cont1_d_first actual=%h/%h expected=00000200/f", mem_addr, mem_rmask); end
    mem_resp = 1'b1; mem_rdata = 32'hD0D0_0001;
    step(1);
    mem_resp = 1'b0; mem_rdata = 32'h0;
    checks++; if (d_resp !== 1'b1 || d_rdata !== 32'hD0D0_0001) begin failures++; $display("FAIL cont1_d_resp actual=%h/%h expected=1/d0d00001", d_resp, d_rdata); end
    checks++; if (i_resp !== 1'b0 || mem_rmask !== 4'h0) begin failures++; $display("FAIL cont1_idle_gap actual=%h/%h expected=0/0", i_resp, mem_rmask); end
    step(1);
    checks++; if (mem_addr !== 32'h0000_0080 || mem_rmask !== 4'hF) begin failures++; $display("FAIL cont1_i_second actual=%h/%h expected=00000080/f", mem_addr, mem_rmask); end
    mem_resp = 1'b1; mem_rdata = 32'h1111_2222;
    step(1);
    mem_resp = 1'b0; mem_rdata = 32'h0;
    checks++; if (i_resp !== 1'b1 || i_rdata !== 32'h1111_2222) begin failures++; $display("FAIL cont1_i_resp actual=%h/%h expected=1/11112222", i_resp, i_rdata); end
    step(1);
  endtask

  task automatic test_d_write();
    d_addr = 32'h0000_0100; d_wmask = 4'h3; d_wdata = 32'h1234_5678;
    step(1);
    d_addr = 32'h0; d_wmask = 4'h0; d_wdata = 32'h0;
    step(1);
    checks++; if (mem_wmask !== 4'h3 || mem_rmask !== 4'h0) begin failures++; $display("FAIL dwr_masks actual=%h/%h expected=3/0", mem_wmask, mem_rmask); end
    checks++; if (mem_wdata !== 32'h1234_5678 || mem_addr !== 32'h0000_0100) begin failures++; $display("FAIL dwr_data_addr actual=%h/%h expected=12345678/00000100", mem_wdata, mem_addr); end
    mem_resp = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step(1);
    mem_resp = 1'b0; mem_rdata = 32'h0;
    checks++; if (d_resp !== 1'b1 || d_rdata !== 32'h0) begin failures++; $display("FAIL dwr_resp actual=%h/%h expected=1/00000000", d_resp, d_rdata); end
    checks++; if (mem_wmask !== 4'h0 || mem_wdata !== 32'h1234_5678) begin failures++; $display("FAIL dwr_hold actual=%h/%h expected=0/12345678", mem_wmask, mem_wdata); end
    step(1);
  endtask

  task automatic test_contention_repeat();
    i_addr = 32'h0000_0084; i_rmask = 4'hF;
    d_addr = 32'h0000_0204; d_rmask = 4'hF;
    step(1);
    i_addr = 32'h0; i_rmask = 4'h0; d_addr = 32'h0; d_rmask = 4'h0;
    step(1);
    checks++; if (mem_addr !== 32'h0000_0084 || mem_rmask !== 4'hF) begin failures++; $display("FAIL cont2_i_first actual=%h/%h expected=00000084/f", mem_addr, mem_rmask); end
    mem_resp = 1'b1; mem_rdata = 32'hAAAA_0001;
    step(1);
    mem_resp = 1'b0; mem_rdata = 32'h0;
    checks++; if (i_resp !== 1'b1 || i_rdata !== 32'hAAAA_0001) begin failures++; $display("FAIL cont2_i_resp actual=%h/%h expected=1/aaaa0001", i_resp, i_rdata); end
    step(1);
    checks++; if (mem_addr !== 32'h0000_0204 || mem_rmask !== 4'hF) begin failures++; $display("FAIL cont2_d_second actual=%h/%h expected=00000204/f", mem_addr, mem_rmask); end
    mem_resp = 1'b1; mem_rdata = 32'hBBBB_0002;
    step(1);
    mem_resp = 1'b0; mem_rdata = 32'h0;
    checks++; if (d_resp !== 1'b1 || d_rdata !== 32'hBBBB_0002) begin failures++; $display("FAIL cont2_d_resp actual=%h/%h expected=1/bbbb0002", d_resp, d_rdata); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL cont2_error actual=%h expected=0", error); end
    step(1);
  endtask

  task automatic test_protocol_errors();
    do_reset();
    d_addr = 32'h0000_0010; d_rmask = 4'hF; d_wmask = 4'hF;
    step(1);
    d_addr = 32'h0; d_rmask = 4'h0; d_wmask = 4'h0;
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL perr_rw_error actual=%h expected=1", error); end
    step(2);
    checks++; if (mem_rmask !== 4'h0 || mem_wmask !== 4'h0) begin failures++; $display("FAIL perr_rw_no_access actual=%h/%h expected=0/0", mem_rmask, mem_wmask); end

    do_reset();
    i_addr = 32'h0000_0002; i_rmask = 4'hF;
    step(1);
    i_addr = 32'h0; i_rmask = 4'h0;
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL perr_misalign_error actual=%h expected=1", error); end
    step(1);
    checks++; if (mem_rmask !== 4'h0) begin failures++; $display("FAIL perr_misalign_no_access actual=%h expected=0", mem_rmask); end

    do_reset();
    i_addr = 32'h0000_0040; i_rmask = 4'hF;
    step(1);
    i_addr = 32'h0; i_rmask = 4'h0;
    step(1);
    checks++; if (error !== 1'b0 || mem_rmask !== 4'hF) begin failures++; $display("FAIL perr_first_ok actual=%h/%h expected=0/f", error, mem_rmask); end
    i_addr = 32'h0000_0044; i_rmask = 4'hF;
    step(1);
    i_addr = 32'h0; i_rmask = 4'h0;
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL perr_busy_error actual=%h expected=1", error); end
    mem_resp = 1'b1; mem_rdata = 32'h0000_4040;
    step(1);
    mem_resp = 1'b0; mem_rdata = 32'h0;
    checks++; if (i_resp !== 1'b1 || i_rdata !== 32'h0000_4040) begin failures++; $display("FAIL perr_busy_first_resp actual=%h/%h expected=1/00004040", i_resp, i_rdata); end
    step(1);
    checks++; if (mem_rmask !== 4'h0) begin failures++; $display("FAIL perr_busy_no_access actual=%h expected=0", mem_rmask); end
    step(1);
    checks++; if (mem_rmask !== 4'h0 || mem_addr !== 32'h0000_0040) begin failures++; $display("FAIL perr_busy_no_access2 actual=%h/%h expected=0/00000040", mem_rmask, mem_addr); end

    do_reset();
    mem_resp = 1'b1;
    step(1);
    mem_resp = 1'b0;
    checks++; if (error !== 1'b1 || i_resp !== 1'b0 || d_resp !== 1'b0) begin failures++; $display("FAIL perr_spurious actual=%h/%h/%h expected=1/0/0", error, i_resp, d_resp); end
  endtask

  task automatic test_timeout();
    do_reset();
    i_addr = 32'h0000_0020; i_rmask = 4'hF;
    step(1);
    i_addr = 32'h0; i_rmask = 4'h0;
    step(1);
    checks++; if (mem_rmask !== 4'hF) begin failures++; $display("FAIL tmo_issue actual=%h expected=f", mem_rmask); end
    step(7);
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL tmo_early actual=%h expected=0", error); end
    step(1);
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL tmo_error actual=%h expected=1", error); end
    step(3);
    checks++; if (i_resp !== 1'b0 || mem_rmask !== 4'h0) begin failures++; $display("FAIL tmo_still_waiting actual=%h/%h expected=0/0", i_resp, mem_rmask); end
    mem_resp = 1'b1; mem_rdata = 32'hCAFE_F00D;
    step(1);
    mem_resp = 1'b0; mem_rdata = 32'h0;
    checks++; if (i_resp !== 1'b1 || i_rdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL tmo_late_resp actual=%h/%h expected=1/cafef00d", i_resp, i_rdata); end
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL tmo_sticky actual=%h expected=1", error); end
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    d_addr = 32'h0000_0300; d_rmask = 4'hF;
    step(1);
    d_addr = 32'h0; d_rmask = 4'h0;
    step(2);
    checks++; if (mem_addr !== 32'h0000_0300) begin failures++; $display("FAIL rmid_wait_addr actual=%h expected=00000300", mem_addr); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mem_addr !== 32'h0 || mem_rmask !== 4'h0 || mem_wdata !== 32'h0) begin failures++; $display("FAIL rmid_async_mem actual=%h/%h/%h expected=0/0/0", mem_addr, mem_rmask, mem_wdata); end
    checks++; if (d_resp !== 1'b0 || d_rdata !== 32'h0 || error !== 1'b0) begin failures++; $display("FAIL rmid_async_up actual=%h/%h/%h expected=0/0/0", d_resp, d_rdata, error); end
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    i_addr = 32'h0000_0044; i_rmask = 4'hF;
    step(1);
    i_addr = 32'h0; i_rmask = 4'h0;
    step(1);
    checks++; if (mem_addr !== 32'h0000_0044 || mem_rmask !== 4'hF) begin failures++; $display("FAIL rmid_new_issue actual=%h/%h expected=00000044/f", mem_addr, mem_rmask); end
    mem_resp = 1'b1; mem_rdata = 32'h5555_AAAA;
    step(1);
    mem_resp = 1'b0; mem_rdata = 32'h0;
    checks++; if (i_resp !== 1'b1 || i_rdata !== 32'h5555_AAAA) begin failures++; $display("FAIL rmid_new_resp actual=%h/%h expected=1/5555aaaa", i_resp, i_rdata); end
    checks++; if (error !== 1'b0 || d_resp !== 1'b0) begin failures++; $display("FAIL rmid_clean actual=%h/%h expected=0/0", error, d_resp); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_single_i();
    test_contention_first();
    test_d_write();
    test_contention_repeat();
    test_protocol_errors();
    test_timeout();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported memory interface between the instruction-fetch requester (I-port) and the load/store requester (D-port) of the pipeline. Each upstream port issues one-cycle request pulses in the same addr/rmask/wmask/wdata/rdata/resp style the memory model uses. The block buffers one outstanding request per port, arbitrates round-robin, and issues exactly one downstream access at a time. It returns the response to the owning port and flags protocol violations and stalled memory.

## Interface

- TIMEOUT_CYCLES, 64: cycles waiting on `mem_resp` before `error` is raised; range 2..65535.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- i_addr  in  32  I-port byte address, valid when `i_rmask != 0`.
- i_rmask  in  4  I-port read byte mask; nonzero for one cycle = request.
- i_rdata  out  32  I-port read data, valid while `i_resp`.
- i_resp  out  1  I-port response, one-cycle pulse.
- d_addr  in  32  D-port byte address.
- d_rmask  in  4  D-port read mask; nonzero for one cycle = read request.
- d_wmask  in  4  D-port write mask; nonzero for one cycle = write request.
- d_wdata  in  32  D-port write data, sampled with `d_wmask`.
- d_rdata  out  32  D-port read data, valid while `d_resp`.
- d_resp  out  1  D-port response, one-cycle pulse (reads and writes).
- mem_addr  out  32  downstream address.
- mem_rmask  out  4  downstream read mask, one-cycle pulse.
- mem_wmask  out  4  downstream write mask, one-cycle pulse.
- mem_wdata  out  32  downstream write data.
- mem_rdata  in  32  downstream read data, valid with `mem_resp`.
- mem_resp  in  1  downstream completion.
- error  out  1  sticky violation flag.

## Operation

- **Pending buffers.** Each port has one pending slot holding addr, masks, wdata and a valid bit. A request is sampled at the edge where its mask is nonzero. The slot stays valid until that request's response has been returned.
- **Rejected requests.** Each of the following drops the request (no slot load, no response) and sets `error`:
  - a new request on a port whose slot is valid;
  - `d_rmask != 0` and `d_wmask != 0` in the same cycle;
  - `addr[1:0] != 0` with any mask nonzero.
- **State machine.** States IDLE, WAIT_I, WAIT_D.
  - IDLE with no valid slot: stay in IDLE.
  - IDLE with exactly one valid slot: issue that slot.
  - IDLE with both slots valid: issue the port not granted last. The last-grant pointer resets to "I", so D wins the first contention.
  - Issue: load `mem_*` registers from the slot, update the last-grant pointer, go to WAIT_I or WAIT_D.
  - WAIT_x with `mem_resp` sampled high: clear slot x, copy `mem_rdata` to `x_rdata`, pulse `x_resp`, go to IDLE.
- **Downstream masks.** `mem_rmask` and `mem_wmask` are high for exactly the cycle after the issue edge, then 0. `mem_addr` and `mem_wdata` hold their last issued values.
- **Response data.** `x_rdata` is 0 whenever `x_resp` is low. A D-port write response returns `d_rdata = 0`.
- **Spurious response.** `mem_resp` in IDLE is ignored and sets `error`.
- **Timeout.** A 16-bit counter clears on issue and increments each WAIT cycle without `mem_resp`. When it reaches TIMEOUT_CYCLES, `error` is set and the block keeps waiting; it never aborts the access.
- **Error flag.** `error` is sticky until reset.

## Timing

- **Reset values.** State IDLE, slots invalid, last-grant = I, counter 0. Outputs: `i_resp = d_resp = 0`, `i_rdata = d_rdata = 0`, all `mem_*` outputs 0, `error = 0`.
- **Reset mid-operation.** Asserting `rst_n` low clears everything immediately (asynchronous). Any in-flight downstream access is abandoned; a later `mem_resp` arriving in IDLE flags `error`.
- **Latency**, with upstream request sampled at edge E0:
  - issue at E1;
  - `mem_*mask` high between E1 and E2;
  - `mem_resp` sampled at Ek;
  - `x_resp` high between Ek and Ek+1.
  - Minimum total (memory responding at E2) is 3 cycles.
- **Back-to-back.** Second-port slot issues at Ek+1, so at most one IDLE edge separates accesses.
- **Requests during responses.**
  - A port may re-request in the cycle its `x_resp` is high; the slot was cleared at Ek, so the request is accepted.
  - A request from port x sampled at the same edge that completes port x's access is rejected (slot still valid at sample time).
- **Simultaneous arrival.** Requests on both ports at the same edge are both accepted; arbitration applies at the next IDLE edge.

## Test plan

- **Single I read.** I read addr 0x0000_0040, rmask 0xF; memory responds 5 cycles after its request with 0xDEADBEEF -> `mem_rmask = 0xF` for exactly 1 cycle; `i_resp` 1 cycle with `i_rdata = 0xDEADBEEF`; `error = 0`.
- **Contention after reset.** I and D requests at the same edge -> D issued first, I issued 1 cycle after `d_resp`. Repeat the contention -> I issued first.
- **D write.** Addr 0x100, wmask 0x3, wdata 0x1234_5678 -> `mem_wmask = 0x3`, `mem_wdata = 0x12345678`, `mem_rmask = 0`; `d_resp` with `d_rdata = 0`.
- **Protocol errors.** Each case sets `error` and produces no extra downstream access:
  - D request with rmask = wmask = 0xF;
  - I request at addr 0x2;
  - second I request while the first is outstanding.
- **Timeout.** TIMEOUT_CYCLES = 8, memory silent -> `error` rises on the 8th WAIT cycle. A later `mem_resp` still delivers `i_resp`.
- **Reset mid-access.** `rst_n` pulsed low during WAIT_D -> all outputs return to reset values asynchronously. A new I request afterwards completes normally.
